autosa_dbb_axi_slave: RTL and testbench

- AXI-style responder at the far end of the accelerator's dbb memory port; serves the master's aw/w/b/ar/r channels.
- Backs the port with on-chip SRAM, giving a self-contained memory for simulation and FPGA bring-up.
- Channel set matches the master exactly: no resp fields; burst length is a 4-bit awlen/arlen; beats are 64-bit.
- One outstanding write and one outstanding read, processed independently.

---
 rtl/autosa_dbb_pkg.sv | 8 +
 rtl/autosa_dbb_sram.sv | 25 ++
 rtl/autosa_dbb_axi_slave.sv | 167 ++++++++++++++++
 tb/tb_autosa_dbb_axi_slave.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/autosa_dbb_pkg.sv
// Shared types and constants for the dbb AXI-style SRAM responder.
package autosa_dbb_pkg;
  localparam int         LEN_W    = 4;
  localparam logic [2:0] SIZE_64B = 3'b011;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
endpackage

// File: rtl/autosa_dbb_sram.sv
// Simple dual-port SRAM: byte-enabled write port, 1-cycle synchronous read port.
// A read and write to the same word in one cycle returns the old contents.
module autosa_dbb_sram #(
  parameter int MEM_AW = 12,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                we,
  input  logic [MEM_AW-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                re,
  input  logic [MEM_AW-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [2**MEM_AW];

  // Non-blocking read and write in the same process gives read-first ordering.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we)
      for (int b = 0; b < DATA_W/8; b++)
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
  end
endmodule

// File: rtl/autosa_dbb_axi_slave.sv
// AXI-style responder for the accelerator dbb port, backed by on-chip SRAM.
// One write and one read in flight at a time, handled by independent FSMs.
module autosa_dbb_axi_slave
  import autosa_dbb_pkg::*;
#(
  parameter int               ADDR_W    = 64,
  parameter int               DATA_W    = 64,
  parameter int               ID_W      = 8,
  parameter int               MEM_AW    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                core_clk,
  input  logic                rst,
  input  logic                aw_awvalid,
  output logic                aw_awready,
  input  logic [ID_W-1:0]     aw_awid,
  input  logic [3:0]          aw_awlen,
  input  logic [2:0]          aw_awsize,
  input  logic [ADDR_W-1:0]   aw_awaddr,
  input  logic                w_wvalid,
  output logic                w_wready,
  input  logic [DATA_W-1:0]   w_wdata,
  input  logic [DATA_W/8-1:0] w_wstrb,
  input  logic                w_wlast,
  output logic                b_bvalid,
  input  logic                b_bready,
  output logic [ID_W-1:0]     b_bid,
  input  logic                ar_arvalid,
  output logic                ar_arready,
  input  logic [ID_W-1:0]     ar_arid,
  input  logic [3:0]          ar_arlen,
  input  logic [2:0]          ar_arsize,
  input  logic [ADDR_W-1:0]   ar_araddr,
  output logic                r_rvalid,
  input  logic                r_rready,
  output logic [ID_W-1:0]     r_rid,
  output logic                r_rlast,
  output logic [DATA_W-1:0]   r_rdata,
  output logic                protocol_err
);
  w_state_e w_state, w_nxt;
  r_state_e r_state, r_nxt;

  logic              awready_q, arready_q;
  logic [ID_W-1:0]   w_id, r_id_q;
  logic [LEN_W-1:0]  w_len, w_cnt, r_len, r_cnt;
  logic [MEM_AW-1:0] w_idx, r_idx, aw_idx, ar_idx, sram_raddr;
  logic [ADDR_W-1:0] aw_off, ar_off;
  logic [DATA_W-1:0] sram_rdata;
  logic              aw_hs, w_hs, ar_hs, r_hs, w_last_beat, sram_re;
  logic              unused_bits;

  assign aw_off = aw_awaddr - BASE_ADDR;
  assign ar_off = ar_araddr - BASE_ADDR;
  assign aw_idx = aw_off[MEM_AW+2:3];
  assign ar_idx = ar_off[MEM_AW+2:3];
  assign unused_bits = ^{aw_off[ADDR_W-1:MEM_AW+3], aw_off[2:0],
                         ar_off[ADDR_W-1:MEM_AW+3], ar_off[2:0]};

  assign aw_awready = awready_q;
  assign ar_arready = arready_q;
  assign w_wready   = (w_state == W_DATA);
  assign b_bvalid   = (w_state == W_RESP);
  assign b_bid      = w_id;
  assign r_rvalid   = (r_state == R_DATA);
  assign r_rid      = r_id_q;

  assign aw_hs       = aw_awvalid && awready_q;
  assign w_hs        = w_wvalid && w_wready;
  assign ar_hs       = ar_arvalid && arready_q;
  assign r_hs        = r_rvalid && r_rready;
  assign w_last_beat = (w_cnt == w_len);

  // Next read goes out on the AR handshake or on a non-final R handshake.
  assign sram_re    = ar_hs || (r_hs && !r_rlast);
  assign sram_raddr = (r_state == R_IDLE) ? ar_idx : r_idx + 1'b1;

  autosa_dbb_sram #(.MEM_AW(MEM_AW), .DATA_W(DATA_W)) u_sram (
    .clk   (core_clk),
    .we    (w_hs),
    .waddr (w_idx),
    .wdata (w_wdata),
    .wstrb (w_wstrb),
    .re    (sram_re),
    .raddr (sram_raddr),
    .rdata (sram_rdata)
  );

  always_comb begin
    w_nxt = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_nxt = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_nxt = W_RESP;
      W_RESP:  if (b_bready) w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_nxt = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_nxt = R_FETCH;
      R_FETCH: r_nxt = R_DATA;
      R_DATA:  if (r_rready) r_nxt = r_rlast ? R_IDLE : R_FETCH;
      default: r_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      w_id      <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_idx     <= '0;
    end else begin
      w_state   <= w_nxt;
      awready_q <= (w_nxt == W_IDLE);
      if (aw_hs) begin
        w_id  <= aw_awid;
        w_len <= aw_awlen;
        w_cnt <= '0;
        w_idx <= aw_idx;
      end else if (w_hs) begin
        w_cnt <= w_cnt + 1'b1;
        w_idx <= w_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      r_id_q    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= r_nxt;
      arready_q <= (r_nxt == R_IDLE);
      if (ar_hs) begin
        r_id_q <= ar_arid;
        r_len  <= ar_arlen;
        r_cnt  <= '0;
        r_idx  <= ar_idx;
      end else if (r_hs && !r_rlast) begin
        r_cnt <= r_cnt + 1'b1;
        r_idx <= r_idx + 1'b1;
      end
      if (r_state == R_FETCH) begin
        r_rdata <= sram_rdata;
        r_rlast <= (r_cnt == r_len);
      end
    end
  end

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) protocol_err <= 1'b0;
    else if ((aw_hs && aw_awsize != SIZE_64B) || (ar_hs && ar_arsize != SIZE_64B) ||
             (w_hs && (w_wlast != w_last_beat)))
      protocol_err <= 1'b1;
  end
endmodule

// File: tb/tb_autosa_dbb_axi_slave.sv
// Scoreboard bench for autosa_dbb_axi_slave: expected B ids and R beats are
// queued as stimulus is driven and checked by a monitor on the falling edge.
module tb_autosa_dbb_axi_slave;
  localparam logic [2:0] SZ = 3'b011;

  typedef struct {logic [63:0] d; logic [7:0] id; logic last;} rexp_t;

  logic        core_clk = 1'b0, rst = 1'b1;
  logic        aw_awvalid = 0, w_wvalid = 0, w_wlast = 0, b_bready = 1, ar_arvalid = 0;
  logic        r_rready = 1'b1;
  logic [7:0]  aw_awid = 0, ar_arid = 0, w_wstrb = 0, b_bid, r_rid;
  logic [3:0]  aw_awlen = 0, ar_arlen = 0;
  logic [2:0]  aw_awsize = SZ, ar_arsize = SZ;
  logic [63:0] aw_awaddr = 0, ar_araddr = 0, w_wdata = 0, r_rdata;
  logic        aw_awready, w_wready, b_bvalid, ar_arready, r_rvalid, r_rlast, protocol_err;

  int total = 0, bad = 0, cyc = 0;
  bit rnd = 0;
  logic [7:0]  bq[$];
  rexp_t       rq[$];
  logic [63:0] model [int];
  logic [63:0] wbuf [16];

  autosa_dbb_axi_slave dut (
    .core_clk(core_clk), .rst(rst),
    .aw_awvalid(aw_awvalid), .aw_awready(aw_awready), .aw_awid(aw_awid),
    .aw_awlen(aw_awlen), .aw_awsize(aw_awsize), .aw_awaddr(aw_awaddr),
    .w_wvalid(w_wvalid), .w_wready(w_wready), .w_wdata(w_wdata),
    .w_wstrb(w_wstrb), .w_wlast(w_wlast),
    .b_bvalid(b_bvalid), .b_bready(b_bready), .b_bid(b_bid),
    .ar_arvalid(ar_arvalid), .ar_arready(ar_arready), .ar_arid(ar_arid),
    .ar_arlen(ar_arlen), .ar_arsize(ar_arsize), .ar_araddr(ar_araddr),
    .r_rvalid(r_rvalid), .r_rready(r_rready), .r_rid(r_rid),
    .r_rlast(r_rlast), .r_rdata(r_rdata), .protocol_err(protocol_err)
  );

  always #5 core_clk = ~core_clk;
  always @(posedge core_clk) cyc <= cyc + 1;
  always @(posedge core_clk) begin
    #1;
    r_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [63:0] a);
    return int'(a[14:3]);
  endfunction

  function automatic void mwrite(input int k, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] o;
    o = model.exists(k) ? model[k] : 64'h0;
    for (int b = 0; b < 8; b++) if (s[b]) o[b*8 +: 8] = d[b*8 +: 8];
    model[k] = o;
  endfunction

  // Monitor: scoreboard pops, beat latency, and stability under backpressure.
  logic        prev_bv = 0, prev_brdy = 0, prev_rv = 0, prev_rrdy = 0, armed = 0;
  logic [7:0]  prev_bid = 0;
  logic [63:0] prev_rd = 0;
  int          last_hs = 0;
  always @(negedge core_clk) begin
    if (rst) begin
      armed = 0; prev_bv = 0; prev_rv = 0;
    end else begin
      if (prev_bv && !prev_brdy) begin
        chk("b_hold_valid", b_bvalid, 1);
        chk("b_hold_id", b_bid, prev_bid);
      end
      if (prev_rv && !prev_rrdy) chk("r_hold_data", r_rdata, prev_rd);
      if (b_bvalid && b_bready) begin
        if (bq.size() == 0) chk("b_extra", 1, 0);
        else chk("bid", b_bid, bq.pop_front());
      end
      if (ar_arvalid && ar_arready) begin
        armed = 1; last_hs = cyc;
      end
      if (r_rvalid && !prev_rv && armed) chk("r_gap", cyc - last_hs, 2);
      if (r_rvalid && r_rready) begin
        if (rq.size() == 0) chk("r_extra", 1, 0);
        else begin
          rexp_t e;
          e = rq.pop_front();
          chk("rdata", r_rdata, e.d);
          chk("rid", r_rid, e.id);
          chk("rlast", r_rlast, e.last);
        end
        if (r_rlast) armed = 0;
        else last_hs = cyc;
      end
      prev_bv = b_bvalid; prev_brdy = b_bready; prev_bid = b_bid;
      prev_rv = r_rvalid; prev_rrdy = r_rready; prev_rd = r_rdata;
    end
  end

  task automatic wr(input logic [63:0] addr, input int len, input logic [7:0] id,
                    input logic [2:0] size, input logic [7:0] strb, input int early);
    int n;
    @(posedge core_clk); #1;
    aw_awvalid = 1; aw_awid = id; aw_awlen = len[3:0]; aw_awsize = size; aw_awaddr = addr;
    @(negedge core_clk);
    n = 0;
    while (!aw_awready && n < 100) begin @(negedge core_clk); n++; end
    if (!aw_awready) chk("aw_timeout", 0, 1);
    @(posedge core_clk); #1;
    aw_awvalid = 0; aw_awsize = SZ;
    bq.push_back(id);
    for (int i = 0; i <= len; i++) begin
      w_wvalid = 1; w_wdata = wbuf[i]; w_wstrb = strb;
      w_wlast = (early >= 0) ? (i == early) : (i == len);
      @(negedge core_clk);
      if (i > 0) chk("w_busy", w_wready, 1);
      n = 0;
      while (!w_wready && n < 100) begin @(negedge core_clk); n++; end
      if (!w_wready) chk("w_timeout", 0, 1);
      @(posedge core_clk); #1;
      mwrite((widx(addr) + i) % 4096, wbuf[i], strb);
      w_wvalid = 0; w_wlast = 0;
    end
  endtask

  task automatic wait_b();
    int n = 0;
    while (bq.size() > 0 && n < 200) begin @(negedge core_clk); n++; end
    if (bq.size() > 0) begin chk("b_timeout", bq.size(), 0); bq.delete(); end
  endtask

  task automatic rd(input logic [63:0] addr, input int len, input logic [7:0] id);
    int n;
    for (int i = 0; i <= len; i++) begin
      rexp_t e;
      int k;
      k = (widx(addr) + i) % 4096;
      e.d = model.exists(k) ? model[k] : 64'h0;
      e.id = id; e.last = (i == len);
      rq.push_back(e);
    end
    @(posedge core_clk); #1;
    ar_arvalid = 1; ar_arid = id; ar_arlen = len[3:0]; ar_araddr = addr;
    @(negedge core_clk);
    n = 0;
    while (!ar_arready && n < 100) begin @(negedge core_clk); n++; end
    if (!ar_arready) chk("ar_timeout", 0, 1);
    @(posedge core_clk); #1;
    ar_arvalid = 0;
    n = 0;
    while (rq.size() > 0 && n < 400) begin @(negedge core_clk); n++; end
    if (rq.size() > 0) begin chk("r_timeout", rq.size(), 0); rq.delete(); end
  endtask

  task automatic do_reset();
    @(posedge core_clk); #1 rst = 1;
    repeat (2) @(posedge core_clk);
    #1 rst = 0;
    @(posedge core_clk);
    @(negedge core_clk);
    chk("perr_after_rst", protocol_err, 0);
  endtask

  initial begin
    // Reset state and release
    repeat (2) @(negedge core_clk);
    chk("rst_awready", aw_awready, 0);
    chk("rst_arready", ar_arready, 0);
    chk("rst_bvalid", b_bvalid, 0);
    chk("rst_rvalid", r_rvalid, 0);
    chk("rst_perr", protocol_err, 0);
    @(posedge core_clk); #1 rst = 0;
    @(posedge core_clk);
    @(negedge core_clk);
    chk("awready_after_rst", aw_awready, 1);
    chk("arready_after_rst", ar_arready, 1);

    // Single beat write then read
    wbuf[0] = 64'hDEADBEEF_CAFEF00D;
    wr(64'h40, 0, 8'h12, SZ, 8'hFF, -1);
    wait_b();
    rd(64'h40, 0, 8'h34);

    // 16-beat burst
    for (int i = 0; i < 16; i++) wbuf[i] = 64'(i + 1);
    wr(64'h100, 15, 8'h21, SZ, 8'hFF, -1);
    wait_b();
    rd(64'h100, 15, 8'h22);

    // Strobed write over prefilled word
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    wr(64'h200, 0, 8'h31, SZ, 8'hFF, -1);
    wait_b();
    wbuf[0] = 64'h0;
    wr(64'h200, 0, 8'h32, SZ, 8'h0F, -1);
    wait_b();
    chk("strobe_model", model[widx(64'h200)], 64'hFFFF_FFFF_0000_0000);
    rd(64'h200, 0, 8'h33);
    chk("perr_clean", protocol_err, 0);

    // B backpressure
    b_bready = 0;
    wbuf[0] = 64'h1234_5678_9ABC_DEF0;
    wr(64'h300, 0, 8'h5A, SZ, 8'hFF, -1);
    for (int i = 0; i < 5; i++) begin
      @(negedge core_clk);
      chk("bp_bvalid", b_bvalid, 1);
      chk("bp_bid", b_bid, 8'h5A);
      chk("bp_awready", aw_awready, 0);
    end
    @(posedge core_clk); #1 b_bready = 1;
    wait_b();

    // Wrap at the last SRAM word, random rready
    for (int i = 0; i < 4; i++) wbuf[i] = {$urandom(), $urandom()};
    wr(64'h7FF8, 3, 8'h41, SZ, 8'hFF, -1);
    wait_b();
    rnd = 1;
    rd(64'h7FF8, 3, 8'h42);
    rnd = 0;

    // Protocol errors
    wbuf[0] = 64'hA5A5_5A5A_0F0F_F0F0;
    wr(64'h400, 0, 8'h51, 3'b010, 8'hFF, -1);
    wait_b();
    @(negedge core_clk);
    chk("perr_size", protocol_err, 1);
    rd(64'h400, 0, 8'h52);
    do_reset();
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h600 + 64'(i);
    wr(64'h600, 3, 8'h61, SZ, 8'hFF, 1);
    wait_b();
    chk("perr_wlast", protocol_err, 1);
    rd(64'h600, 3, 8'h62);

    // Reset in the middle of a len-7 write
    for (int i = 0; i < 8; i++) wbuf[i] = 64'hB000 + 64'(i);
    @(posedge core_clk); #1;
    aw_awvalid = 1; aw_awid = 8'h71; aw_awlen = 4'd7; aw_awaddr = 64'h800;
    @(negedge core_clk);
    chk("mid_awready", aw_awready, 1);
    @(posedge core_clk); #1 aw_awvalid = 0;
    for (int i = 0; i < 2; i++) begin
      w_wvalid = 1; w_wdata = wbuf[i]; w_wstrb = 8'hFF; w_wlast = 0;
      @(negedge core_clk);
      chk("mid_wready", w_wready, 1);
      @(posedge core_clk); #1;
      mwrite(widx(64'h800) + i, wbuf[i], 8'hFF);
    end
    w_wdata = wbuf[2];
    #2 rst = 1;
    #1;
    chk("mid_rst_awready", aw_awready, 0);
    chk("mid_rst_wready", w_wready, 0);
    chk("mid_rst_bvalid", b_bvalid, 0);
    chk("mid_rst_arready", ar_arready, 0);
    chk("mid_rst_rvalid", r_rvalid, 0);
    w_wvalid = 0;
    repeat (2) @(posedge core_clk);
    #1 rst = 0;
    @(posedge core_clk);
    @(negedge core_clk);
    chk("mid_rel_awready", aw_awready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge core_clk);
      chk("mid_no_bvalid", b_bvalid, 0);
    end
    rd(64'h800, 1, 8'h72);

    repeat (3) @(negedge core_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
